// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-side responder for the MEM stage. It stands in for a data cache
// between the pipeline and the memory controller. Each dmemREN/dmemWEN
// request is captured and replayed onto a single-ported RAM bus. The block
// then waits for ramstate to report ACCESS and answers the pipeline with a
// one-cycle dhit pulse.
//
// Optional feature macro: DMEM_ATOMIC_EN
//   defined   : datomic turns a load into LL and a store into SC. An internal
//               link register (link_valid/link_addr) decides whether an SC
//               may write memory.
//   undefined : datomic is ignored and no link register exists. SC is then a
//               plain store that returns 0, and LL is a plain load.
//
// Parameters
//   MAX_WAIT : WAIT cycles allowed before a request is abandoned (1..255).
//   WORD_LSB : low address bits ignored when comparing against the link.
//
// Ports
//   CLK, nRST  : clock; asynchronous active-low reset.
//   dmemREN    : load request from MEM stage.
//   dmemWEN    : store request from MEM stage (wins if both are high).
//   datomic    : LL/SC qualifier.
//   dmemaddr   : byte address of the request.
//   dmemstore  : store data.
//   dhit       : request-complete pulse (one cycle).
//   dmemload   : load data, or SC result flag; held until next completion.
//   ramREN     : RAM read enable  (WAIT state only).
//   ramWEN     : RAM write enable (WAIT state only).
//   ramaddr    : RAM address (captured request address, 0 outside WAIT).
//   ramstore   : RAM write data (captured store data, 0 outside WAIT).
//   ramload    : RAM read data.
//   ramstate   : memory controller state: FREE, BUSY, ACCESS, ERROR.
//   derror     : sticky error flag, cleared only by reset.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int MAX_WAIT = 255,
  parameter int WORD_LSB = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        derror
);

  // Encoding of ramstate_t (FREE, BUSY, ACCESS, ERROR).
  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] store_q, store_n;
  logic        write_q, write_n;
  logic [7:0]  wait_cnt, wait_n;
  logic [31:0] load_q, load_n;
  logic        err_q, err_n;

`ifdef DMEM_ATOMIC_EN
  logic        atomic_q, atomic_n;
  logic        link_valid, link_valid_n;
  logic [31:0] link_addr, link_addr_n;
  logic        sc_reject;
  logic        link_hit;
`else
  logic        unused_atomic_inputs;
  assign unused_atomic_inputs = datomic ^ (WORD_LSB == 0);
`endif

  assign dmemload = load_q;
  assign derror   = err_q;

`ifdef DMEM_ATOMIC_EN
  // An SC is rejected up front when there is no live link to its word.
  assign sc_reject = dmemWEN && datomic &&
                     (!link_valid ||
                      (link_addr[31:WORD_LSB] != dmemaddr[31:WORD_LSB]));
  // A plain store to the linked word breaks the reservation.
  assign link_hit  = (link_addr[31:WORD_LSB] == addr_q[31:WORD_LSB]);
`endif

  // State and datapath registers. Reset discards any transaction in
  // flight. Because the RAM enables decode from state, they drop at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      write_q  <= 1'b0;
      wait_cnt <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
`ifdef DMEM_ATOMIC_EN
      atomic_q   <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
`endif
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      store_q  <= store_n;
      write_q  <= write_n;
      wait_cnt <= wait_n;
      load_q   <= load_n;
      err_q    <= err_n;
`ifdef DMEM_ATOMIC_EN
      atomic_q   <= atomic_n;
      link_valid <= link_valid_n;
      link_addr  <= link_addr_n;
`endif
    end
  end

  // Next-state and output decode. The RAM bus is driven only in WAIT,
  // straight from the captured request, so it stays stable while the
  // controller is busy.
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    store_n  = store_q;
    write_n  = write_q;
    wait_n   = wait_cnt;
    load_n   = load_q;
    err_n    = err_q;
    dhit     = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
`ifdef DMEM_ATOMIC_EN
    atomic_n     = atomic_q;
    link_valid_n = link_valid;
    link_addr_n  = link_addr;
`endif

    case (state)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          addr_n  = dmemaddr;
          store_n = dmemstore;
          write_n = dmemWEN;
          wait_n  = '0;
          state_n = WAIT;
`ifdef DMEM_ATOMIC_EN
          atomic_n = datomic;
          if (sc_reject) begin
            load_n  = '0;
            state_n = DONE;
          end
`endif
        end
      end

      WAIT: begin
        ramREN   = !write_q;
        ramWEN   = write_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (ramstate == RAM_ACCESS) begin
          state_n = DONE;
          if (write_q) begin
            load_n = '0;
`ifdef DMEM_ATOMIC_EN
            if (atomic_q) begin
              load_n       = 32'd1;
              link_valid_n = 1'b0;
            end else if (link_hit) begin
              link_valid_n = 1'b0;
            end
`endif
          end else begin
            load_n = ramload;
`ifdef DMEM_ATOMIC_EN
            if (atomic_q) begin
              link_valid_n = 1'b1;
              link_addr_n  = addr_q;
            end
`endif
          end
        end else if ((ramstate == RAM_ERROR) || (wait_cnt == WAIT_LAST)) begin
          // The request is abandoned and the link is left untouched.
          err_n   = 1'b1;
          load_n  = '0;
          state_n = DONE;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end

      DONE: begin
        dhit    = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FREE and BUSY both mean "keep waiting". They are named so the decode
  // above reads against the full controller encoding.
  logic unused_ram_states;
  assign unused_ram_states = (RAM_FREE == RAM_BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Table-driven bench for dmem_responder, built with MAX_WAIT=4. Each record
// holds one request, how the RAM should answer it, and the expected
// completion. The expected completion is queued when the request is driven
// and popped when dhit appears. A hand-written sequence covers reset in the
// middle of a WAIT. The expected values follow DMEM_ATOMIC_EN.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

`ifdef DMEM_ATOMIC_EN
  localparam bit ATOM = 1'b1;
`else
  localparam bit ATOM = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic        datomic = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic [1:0]  ramstate = S_FREE;
  logic        derror;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        ren;
    logic        wen;
    logic        atomic;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          busy_n;
    logic [1:0]  final_st;
    logic [31:0] exp_load;
    int          exp_waits;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    int          waits;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  dmem_responder #(
    .MAX_WAIT(4),
    .WORD_LSB(2)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .datomic  (datomic),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .dhit     (dhit),
    .dmemload (dmemload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .derror   (derror)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  // One comparison: count it and report it if it does not match.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ren, input logic wen,
                              input logic atomic, input logic [31:0] addr,
                              input logic [31:0] store,
                              input logic [31:0] rdata, input int busy_n,
                              input logic [1:0] final_st,
                              input logic [31:0] exp_load,
                              input int exp_waits, input logic exp_err);
    vec_t v;
    v.ren = ren; v.wen = wen; v.atomic = atomic; v.addr = addr;
    v.store = store; v.rdata = rdata; v.busy_n = busy_n;
    v.final_st = final_st; v.exp_load = exp_load;
    v.exp_waits = exp_waits; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic dropRequest();
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    datomic  = 1'b0;
    ramstate = S_FREE;
  endtask

  // Drive one request and act as the RAM controller while it is in WAIT.
  // The completion is checked against the scoreboard entry queued here.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   got;
    int   waits;
    @(negedge CLK);
    dmemREN   = v.ren;
    dmemWEN   = v.wen;
    datomic   = v.atomic;
    dmemaddr  = v.addr;
    dmemstore = v.store;
    ramload   = v.rdata;
    ramstate  = S_FREE;
    e.load  = v.exp_load;
    e.waits = v.exp_waits;
    e.err   = v.exp_err;
    sb.push_back(e);
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (dhit) begin
        got = 1'b1;
        dropRequest();
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL scoreboard: dhit with no queued request");
        end else begin
          e = sb.pop_front();
          checkOutput("dmemload", dmemload, e.load);
          checkOutput("derror", {31'd0, derror}, {31'd0, e.err});
          checkOutput("wait_cycles", waits, e.waits);
        end
      end else if (ramREN || ramWEN) begin
        checkOutput("ramWEN", {31'd0, ramWEN}, {31'd0, v.wen});
        checkOutput("ramREN", {31'd0, ramREN}, {31'd0, !v.wen});
        checkOutput("ramaddr", ramaddr, v.addr);
        checkOutput("ramstore", ramstore, v.store);
        ramstate = (waits < v.busy_n) ? S_BUSY : v.final_st;
        waits++;
      end else begin
        ramstate = S_FREE;
      end
    end
    if (!got) begin
      tests++;
      failed++;
      $display("[TB] FAIL dhit_timeout: no dhit for request at 0x%08h", v.addr);
      dropRequest();
      void'(sb.pop_front());
    end else begin
      @(negedge CLK);
      checkOutput("dhit_pulse", {31'd0, dhit}, 32'd0);
    end
  endtask

  // Reset in the middle of a load's WAIT. The enables must drop
  // immediately, sticky state must clear, and no dhit may follow.
  task automatic resetMidWait();
    @(negedge CLK);
    dmemREN  = 1'b1;
    dmemaddr = 32'h0000_0600;
    ramstate = S_BUSY;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("rst_pre_ramREN", {31'd0, ramREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("rst_ramREN", {31'd0, ramREN}, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    checkOutput("rst_dhit", {31'd0, dhit}, 32'd0);
    checkOutput("rst_derror", {31'd0, derror}, 32'd0);
    checkOutput("rst_dmemload", dmemload, 32'd0);
    dropRequest();
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checkOutput("rst_no_dhit", {31'd0, dhit}, 32'd0);
      checkOutput("rst_no_ram", {30'd0, ramREN, ramWEN}, 32'd0);
    end
  endtask

  initial begin
    int reset_at;

    // Plain load after two BUSY cycles, then plain store with immediate
    // ACCESS.
    vecs.push_back(mk(1, 0, 0, 32'h40, 32'h0, 32'hDEAD_BEEF, 2, S_ACCESS,
                      32'hDEAD_BEEF, 3, 0));
    vecs.push_back(mk(0, 1, 0, 32'h80, 32'h1234_5678, 32'h0, 0, S_ACCESS,
                      32'h0, 1, 0));
    // LL 0x100, a successful SC, then a second SC that finds no link.
    vecs.push_back(mk(1, 0, 1, 32'h100, 32'h0, 32'hAAAA_5555, 0, S_ACCESS,
                      32'hAAAA_5555, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h100, 32'h5, 32'h0, 0, S_ACCESS,
                      ATOM ? 32'h1 : 32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h100, 32'h7, 32'h0, 0, S_ACCESS,
                      32'h0, ATOM ? 0 : 1, 0));
    // A store to 0x202 (same word) breaks the link to 0x200.
    vecs.push_back(mk(1, 0, 1, 32'h200, 32'h0, 32'h77, 0, S_ACCESS,
                      32'h77, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h202, 32'h9, 32'h0, 0, S_ACCESS,
                      32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h200, 32'h5, 32'h0, 0, S_ACCESS,
                      32'h0, ATOM ? 0 : 1, 0));
    // A store to 0x204 (next word) leaves the link to 0x200 intact.
    vecs.push_back(mk(1, 0, 1, 32'h200, 32'h0, 32'h88, 0, S_ACCESS,
                      32'h88, 1, 0));
    vecs.push_back(mk(0, 1, 0, 32'h204, 32'hA, 32'h0, 0, S_ACCESS,
                      32'h0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h200, 32'h6, 32'h0, 0, S_ACCESS,
                      ATOM ? 32'h1 : 32'h0, 1, 0));
    // REN and WEN both high is handled as a write.
    vecs.push_back(mk(1, 1, 0, 32'h300, 32'hCAFE_F00D, 32'h5555_0000, 0,
                      S_ACCESS, 32'h0, 1, 0));
    // Link 0x500 here. The mid-WAIT reset below must clear it.
    vecs.push_back(mk(1, 0, 1, 32'h500, 32'h0, 32'h99, 0, S_ACCESS,
                      32'h99, 1, 0));
    // Controller ERROR, then timeout after MAX_WAIT cycles, then sticky
    // derror across a good load.
    vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0, 32'h1111_2222, 1, S_ERROR,
                      32'h0, 2, 1));
    vecs.push_back(mk(1, 0, 0, 32'h44, 32'h0, 32'h3333_4444, 100, S_BUSY,
                      32'h0, 4, 1));
    vecs.push_back(mk(1, 0, 0, 32'h48, 32'h0, 32'h1111, 0, S_ACCESS,
                      32'h1111, 1, 1));
    reset_at = vecs.size();
    // After reset: SC to the old link fails, and a fresh LL/SC pair works.
    vecs.push_back(mk(0, 1, 1, 32'h500, 32'h3, 32'h0, 0, S_ACCESS,
                      32'h0, ATOM ? 0 : 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h100, 32'h0, 32'h42, 0, S_ACCESS,
                      32'h42, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h100, 32'h8, 32'h0, 0, S_ACCESS,
                      ATOM ? 32'h1 : 32'h0, 1, 0));

    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_dhit", {31'd0, dhit}, 32'd0);
    checkOutput("reset_dmemload", dmemload, 32'd0);
    checkOutput("reset_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
    checkOutput("reset_ramaddr", ramaddr, 32'd0);
    checkOutput("reset_ramstore", ramstore, 32'd0);
    checkOutput("reset_derror", {31'd0, derror}, 32'd0);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == reset_at) resetMidWait();
      applyStimulus(vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
